// File: rtl/cache_rd_arbiter.sv
// Arbitrates the shared bridge read channel between icache and dcache, one burst at a time.
// Request path and return steering are combinational; new requests stall while a burst is outstanding.
module cache_rd_arbiter #(
  parameter int MAX_BEATS   = 8,
  parameter bit DCACHE_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_rd_req,
  input  logic [2:0]  i_rd_type,
  input  logic [31:0] i_rd_addr,
  output logic        i_rd_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  input  logic        d_rd_req,
  input  logic [2:0]  d_rd_type,
  input  logic [31:0] d_rd_addr,
  output logic        d_rd_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  output logic        err
);

  localparam int CW = $clog2(MAX_BEATS) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          err_q, err_d;
  logic          win_i, win_d;
  logic [CW-1:0] beat_next;

  // On a tie the dcache wins under fixed priority, otherwise whoever was not granted last.
  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    if (i_rd_req && d_rd_req) begin
      if (DCACHE_PRIO || !last_grant_q) win_d = 1'b1;
      else                              win_i = 1'b1;
    end else if (i_rd_req) begin
      win_i = 1'b1;
    end else if (d_rd_req) begin
      win_d = 1'b1;
    end
  end

  always_comb begin
    i_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    d_rd_rdy    = 1'b0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;
    rd_req      = 1'b0;
    rd_type     = 3'd0;
    rd_addr     = 32'd0;
    err         = 1'b0;
    if (!reset) begin
      err = err_q;
      case (state_q)
        IDLE: begin
          if (win_i) begin
            rd_req   = 1'b1;
            rd_type  = i_rd_type;
            rd_addr  = i_rd_addr;
            i_rd_rdy = rd_rdy;
          end else if (win_d) begin
            rd_req   = 1'b1;
            rd_type  = d_rd_type;
            rd_addr  = d_rd_addr;
            d_rd_rdy = rd_rdy;
          end
        end
        BUSY_I: begin
          i_ret_valid = ret_valid;
          i_ret_last  = ret_valid && ret_last;
        end
        BUSY_D: begin
          d_ret_valid = ret_valid;
          d_ret_last  = ret_valid && ret_last;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    beat_next    = beat_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        // A beat with no owner is dropped and flagged.
        if (ret_valid) err_d = 1'b1;
        if ((win_i || win_d) && rd_rdy) begin
          state_d      = win_d ? BUSY_D : BUSY_I;
          last_grant_d = win_d;
          beat_cnt_d   = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (ret_valid) begin
          beat_cnt_d = beat_next;
          if (ret_last) begin
            state_d = IDLE;
          end else if (beat_next == MAX_CNT) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: round-robin and dcache-priority instances share stimulus
// and are compared every cycle against a transaction-level owner/beat model.
module tb_cache_rd_arbiter;

  localparam int MAXB = 8;

  typedef struct packed {
    logic        i_rd_rdy;
    logic        i_ret_valid;
    logic        i_ret_last;
    logic        d_rd_rdy;
    logic        d_ret_valid;
    logic        d_ret_last;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        err;
  } out_t;

  logic        clock;
  logic        reset;
  logic        i_rd_req, d_rd_req;
  logic [2:0]  i_rd_type, d_rd_type;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic        rd_rdy, ret_valid, ret_last;

  logic        rr_i_rd_rdy, rr_i_ret_valid, rr_i_ret_last;
  logic        rr_d_rd_rdy, rr_d_ret_valid, rr_d_ret_last;
  logic        rr_rd_req, rr_err;
  logic [2:0]  rr_rd_type;
  logic [31:0] rr_rd_addr;
  logic        dp_i_rd_rdy, dp_i_ret_valid, dp_i_ret_last;
  logic        dp_d_rd_rdy, dp_d_ret_valid, dp_d_ret_last;
  logic        dp_rd_req, dp_err;
  logic [2:0]  dp_rd_type;
  logic [31:0] dp_rd_addr;

  out_t got [2];
  int   checks = 0;
  int   fails  = 0;

  // Model: -1 = no burst outstanding, 0 = icache owns it, 1 = dcache owns it.
  int m_owner [2] = '{-1, -1};
  bit m_last  [2] = '{1'b1, 1'b1};
  int m_beats [2] = '{0, 0};
  bit m_err   [2] = '{1'b0, 1'b0};

  cache_rd_arbiter #(.MAX_BEATS(MAXB), .DCACHE_PRIO(1'b0)) u_rr (
    .clock(clock), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(rr_i_rd_rdy),
    .i_ret_valid(rr_i_ret_valid), .i_ret_last(rr_i_ret_last),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(rr_d_rd_rdy),
    .d_ret_valid(rr_d_ret_valid), .d_ret_last(rr_d_ret_last),
    .rd_req(rr_rd_req), .rd_type(rr_rd_type), .rd_addr(rr_rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .err(rr_err)
  );

  cache_rd_arbiter #(.MAX_BEATS(MAXB), .DCACHE_PRIO(1'b1)) u_dp (
    .clock(clock), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(dp_i_rd_rdy),
    .i_ret_valid(dp_i_ret_valid), .i_ret_last(dp_i_ret_last),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(dp_d_rd_rdy),
    .d_ret_valid(dp_d_ret_valid), .d_ret_last(dp_d_ret_last),
    .rd_req(dp_rd_req), .rd_type(dp_rd_type), .rd_addr(dp_rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .err(dp_err)
  );

  always_comb begin
    got[0] = {rr_i_rd_rdy, rr_i_ret_valid, rr_i_ret_last, rr_d_rd_rdy, rr_d_ret_valid,
              rr_d_ret_last, rr_rd_req, rr_rd_type, rr_rd_addr, rr_err};
    got[1] = {dp_i_rd_rdy, dp_i_ret_valid, dp_i_ret_last, dp_d_rd_rdy, dp_d_ret_valid,
              dp_d_ret_last, dp_rd_req, dp_rd_type, dp_rd_addr, dp_err};
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instance p uses dcache-fixed priority when p == 1.
  function automatic int model_winner(input int p);
    if (i_rd_req && d_rd_req) return (p == 1 || !m_last[p]) ? 1 : 0;
    if (i_rd_req) return 0;
    if (d_rd_req) return 1;
    return -1;
  endfunction

  function automatic out_t model_out(input int p);
    out_t o;
    int   w;
    o = '0;
    if (reset) return o;
    o.err = m_err[p];
    if (m_owner[p] < 0) begin
      w = model_winner(p);
      if (w == 0) begin
        o.rd_req = 1'b1; o.rd_type = i_rd_type; o.rd_addr = i_rd_addr; o.i_rd_rdy = rd_rdy;
      end else if (w == 1) begin
        o.rd_req = 1'b1; o.rd_type = d_rd_type; o.rd_addr = d_rd_addr; o.d_rd_rdy = rd_rdy;
      end
    end else if (m_owner[p] == 0) begin
      o.i_ret_valid = ret_valid; o.i_ret_last = ret_valid && ret_last;
    end else begin
      o.d_ret_valid = ret_valid; o.d_ret_last = ret_valid && ret_last;
    end
    return o;
  endfunction

  always @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        m_owner[p] <= -1; m_last[p] <= 1'b1; m_beats[p] <= 0; m_err[p] <= 1'b0;
      end else if (m_owner[p] < 0) begin
        if (ret_valid) m_err[p] <= 1'b1;
        if (model_winner(p) >= 0 && rd_rdy) begin
          m_owner[p] <= model_winner(p);
          m_last[p]  <= (model_winner(p) == 1);
          m_beats[p] <= 0;
        end
      end else if (ret_valid) begin
        m_beats[p] <= m_beats[p] + 1;
        if (ret_last) m_owner[p] <= -1;
        else if (m_beats[p] + 1 >= MAXB) begin
          m_owner[p] <= -1; m_err[p] <= 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    i_rd_req = 1'b0; d_rd_req = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
    i_rd_type = 3'd0; d_rd_type = 3'd0; i_rd_addr = 32'd0; d_rd_addr = 32'd0;
  endtask

  task automatic pulse_reset();
    clr_in(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_rd_req = 1'b1; d_rd_req = 1'b1; rd_rdy = 1'b1; ret_valid = 1'b1; ret_last = 1'b0;
    i_rd_type = 3'd5; i_rd_addr = 32'hAAAA_0000; d_rd_type = 3'd6; d_rd_addr = 32'hBBBB_0000;
    #1;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (got[p] !== '0) begin
        fails++; $display("FAIL reset_during inst=%0d got=%h exp=0", p, got[p]);
      end
    end
    tick();
    reset = 1'b0; clr_in(); rd_rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got[p] !== '0 || got[p] !== model_out(p)) begin
          fails++; $display("FAIL reset_after inst=%0d cyc=%0d got=%h exp=0", p, c, got[p]);
        end
      end
      tick();
    end
    clr_in();
  endtask

  task automatic test_icache_only();
    clr_in(); i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0000; rd_rdy = 1'b1;
    #1;
    checks++;
    if (got[0].i_rd_rdy !== 1'b1 || got[0].d_rd_rdy !== 1'b0 || got[0].rd_req !== 1'b1 ||
        got[0].rd_type !== 3'b100 || got[0].rd_addr !== 32'h1C00_0000) begin
      fails++; $display("FAIL icache_grant got=%h", got[0]);
    end
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (got[p] !== model_out(p)) begin
        fails++; $display("FAIL icache_grant_model inst=%0d got=%h exp=%h", p, got[p], model_out(p));
      end
    end
    tick();
    clr_in();
    for (int b = 1; b <= 4; b++) begin
      ret_valid = 1'b1; ret_last = (b == 4);
      #1;
      checks++;
      if (got[0].i_ret_valid !== 1'b1 || got[0].i_ret_last !== (b == 4) ||
          got[0].d_ret_valid !== 1'b0 || got[0].d_ret_last !== 1'b0) begin
        fails++; $display("FAIL icache_beat b=%0d got=%h", b, got[0]);
      end
      tick();
    end
    clr_in(); d_rd_req = 1'b1; d_rd_addr = 32'h2000_0040;
    #1;
    checks++;
    if (got[0].rd_req !== 1'b1 || got[0].rd_addr !== 32'h2000_0040 || got[0].i_ret_valid !== 1'b0) begin
      fails++; $display("FAIL icache_back_idle got=%h", got[0]);
    end
    tick();
    clr_in();
  endtask

  task automatic run_ties(input int p, input string name);
    pulse_reset();
    clr_in(); i_rd_req = 1'b1; d_rd_req = 1'b1;
    i_rd_addr = 32'h0000_1000; d_rd_addr = 32'h0000_2000; i_rd_type = 3'd1; d_rd_type = 3'd2;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (p == 1) ? 1'b1 : ((k % 2) == 1);
      rd_rdy = 1'b1; ret_valid = 1'b0; ret_last = 1'b0;
      #1;
      checks++;
      if (got[p].d_rd_rdy !== exp_d || got[p].i_rd_rdy !== !exp_d ||
          got[p].rd_addr !== (exp_d ? 32'h0000_2000 : 32'h0000_1000)) begin
        fails++; $display("FAIL %s grant k=%0d got=%h exp_dcache=%0d", name, k, got[p], exp_d);
      end
      checks++;
      if (got[p] !== model_out(p)) begin
        fails++; $display("FAIL %s model k=%0d got=%h exp=%h", name, k, got[p], model_out(p));
      end
      tick();
      rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1;
      #1;
      checks++;
      if (got[p].d_ret_last !== exp_d || got[p].i_ret_last !== !exp_d || got[p].rd_req !== 1'b0) begin
        fails++; $display("FAIL %s beat k=%0d got=%h exp_dcache=%0d", name, k, got[p], exp_d);
      end
      tick();
    end
    clr_in();
  endtask

  task automatic test_round_robin();
    run_ties(0, "round_robin");
  endtask

  task automatic test_dcache_prio();
    run_ties(1, "dcache_prio");
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    clr_in(); d_rd_req = 1'b1; d_rd_addr = 32'h0000_3000; rd_rdy = 1'b1;
    #1;
    checks++;
    if (got[0].d_rd_rdy !== 1'b1) begin
      fails++; $display("FAIL hold_dgrant got=%0b exp=1", got[0].d_rd_rdy);
    end
    tick();
    d_rd_req = 1'b0; i_rd_req = 1'b1; i_rd_addr = 32'h0000_4000;
    for (int b = 1; b <= 3; b++) begin
      ret_valid = 1'b1; ret_last = (b == 3);
      #1;
      checks++;
      if (got[0].i_rd_rdy !== 1'b0 || got[0].rd_req !== 1'b0 || got[0].d_ret_valid !== 1'b1 ||
          got[0].i_ret_valid !== 1'b0 || got[0].d_ret_last !== (b == 3)) begin
        fails++; $display("FAIL hold_busy b=%0d got=%h", b, got[0]);
      end
      tick();
    end
    ret_valid = 1'b0; ret_last = 1'b0;
    #1;
    checks++;
    if (got[0].i_rd_rdy !== 1'b1 || got[0].rd_addr !== 32'h0000_4000 || got[0] !== model_out(0)) begin
      fails++; $display("FAIL hold_igrant got=%h exp=%h", got[0], model_out(0));
    end
    tick();
    i_rd_req = 1'b0; ret_valid = 1'b1; ret_last = 1'b1;
    #1;
    checks++;
    if (got[0].i_ret_last !== 1'b1 || got[0].d_ret_valid !== 1'b0) begin
      fails++; $display("FAIL hold_iburst got=%h", got[0]);
    end
    tick();
    clr_in();
  endtask

  task automatic test_errors();
    pulse_reset();
    clr_in(); ret_valid = 1'b1;
    #1;
    checks++;
    if (got[0].i_ret_valid !== 1'b0 || got[0].d_ret_valid !== 1'b0 || got[0].err !== 1'b0) begin
      fails++; $display("FAIL stray_drop got=%h", got[0]);
    end
    tick();
    clr_in();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (got[0].err !== 1'b1 || got[1].err !== 1'b1) begin
        fails++; $display("FAIL stray_sticky cyc=%0d got=%0b/%0b exp=1", c, got[0].err, got[1].err);
      end
      tick();
    end
    pulse_reset();
    clr_in(); i_rd_req = 1'b1; rd_rdy = 1'b1;
    tick();
    clr_in();
    for (int b = 1; b <= MAXB; b++) begin
      ret_valid = 1'b1;
      #1;
      checks++;
      if (got[0].i_ret_valid !== 1'b1 || got[0].err !== 1'b0) begin
        fails++; $display("FAIL overrun_beat b=%0d got=%h", b, got[0]);
      end
      tick();
    end
    clr_in(); ret_valid = 1'b1; d_rd_req = 1'b1; d_rd_addr = 32'h0000_5000;
    #1;
    checks++;
    if (got[0].err !== 1'b1 || got[0].i_ret_valid !== 1'b0 || got[0].rd_req !== 1'b1 ||
        got[0] !== model_out(0)) begin
      fails++; $display("FAIL overrun_idle got=%h exp=%h", got[0], model_out(0));
    end
    tick();
    clr_in();
    #1;
    checks++;
    if (got[0].err !== 1'b1) begin
      fails++; $display("FAIL overrun_sticky got=%0b exp=1", got[0].err);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    clr_in(); d_rd_req = 1'b1; rd_rdy = 1'b1;
    tick();
    clr_in(); ret_valid = 1'b1;
    tick();
    reset = 1'b1; ret_valid = 1'b1;
    #1;
    checks++;
    if (got[0] !== '0) begin
      fails++; $display("FAIL midrst_during got=%h exp=0", got[0]);
    end
    tick();
    reset = 1'b0; clr_in();
    #1;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (got[p] !== '0) begin
        fails++; $display("FAIL midrst_after inst=%0d got=%h exp=0", p, got[p]);
      end
    end
    tick();
    ret_valid = 1'b1;
    #1;
    checks++;
    if (got[0].d_ret_valid !== 1'b0 || got[0].i_ret_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_stray got=%h", got[0]);
    end
    tick();
    clr_in();
    #1;
    checks++;
    if (got[0].err !== 1'b1) begin
      fails++; $display("FAIL midrst_err got=%0b exp=1", got[0].err);
    end
    tick();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      i_rd_req  = $urandom_range(0, 1);
      d_rd_req  = $urandom_range(0, 1);
      i_rd_type = 3'($urandom);
      d_rd_type = 3'($urandom);
      i_rd_addr = $urandom;
      d_rd_addr = $urandom;
      rd_rdy    = $urandom_range(0, 1);
      ret_valid = ($urandom_range(0, 2) != 0);
      ret_last  = ret_valid && ($urandom_range(0, 3) == 0);
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got[p] !== model_out(p)) begin
          fails++; $display("FAIL random n=%0d inst=%0d got=%h exp=%h", n, p, got[p], model_out(p));
        end
      end
      tick();
    end
    reset = 1'b0;
    clr_in();
  endtask

  initial begin
    test_reset();
    test_icache_only();
    test_round_robin();
    test_dcache_prio();
    test_back_to_back();
    test_errors();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
